// File: rtl/seq_datapath.sv
// -----------------------------------------------------------------------------
// seq_datapath
//
// Single-bus register-transfer datapath with its own micro-step sequencer. One
// start command runs a complete three-step ALU instruction:
//   LOADY : bus = R[ra]         -> RY
//   EXEC  : bus = R[rb]         -> RZ = ALU(RY, bus)   (RZ is 2*DATA_WIDTH wide)
//   WB    : bus = RZ_LO         -> R[rd] / result_out, or HI/LO for MUL
// done (and illegal_op for undefined opcodes) pulse in the cycle after WB, when
// the sequencer is back in IDLE and can already accept the next command.
//
// Ports
//   clock          rising-edge clock
//   clear          synchronous active-high reset (overrides everything)
//   start          command request, sampled only in IDLE
//   op             ALU operation code (0..10 legal, 11..31 illegal)
//   ra_sel/rb_sel  operand A / B register selects
//   rd_sel         destination register select
//   ext_load_*     register preload strobe / target / value (IDLE only)
//   rd_port_sel    debug read select
//   rd_port_data   combinational read of R[rd_port_sel]
//   busy           high while the sequencer is not in IDLE
//   done           one-cycle completion pulse
//   illegal_op     one-cycle pulse alongside done for an undefined op
//   result_out     last low-half result, held until the next done
//   hi_out/lo_out  HI / LO registers written by MUL
// -----------------------------------------------------------------------------
module seq_datapath #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int R0_ZERO    = 0,
  localparam int RSEL_W    = $clog2(NUM_REGS),
  localparam int SH_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic [4:0]            op,
  input  logic [RSEL_W-1:0]     ra_sel,
  input  logic [RSEL_W-1:0]     rb_sel,
  input  logic [RSEL_W-1:0]     rd_sel,
  input  logic                  ext_load_en,
  input  logic [RSEL_W-1:0]     ext_load_sel,
  input  logic [DATA_WIDTH-1:0] ext_load_data,
  input  logic [RSEL_W-1:0]     rd_port_sel,
  output logic [DATA_WIDTH-1:0] rd_port_data,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal_op,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOADY,
    S_EXEC,
    S_WB
  } state_e;

  typedef enum logic [4:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_AND = 5'd2,
    OP_OR  = 5'd3,
    OP_SHR = 5'd4,
    OP_SHL = 5'd5,
    OP_ROR = 5'd6,
    OP_ROL = 5'd7,
    OP_MUL = 5'd8,
    OP_NEG = 5'd9,
    OP_NOT = 5'd10
  } alu_op_e;

  // ---------------------------------------------------------------------------
  // State and latched command
  // ---------------------------------------------------------------------------
  state_e              state, state_nx;
  alu_op_e             op_l;
  logic [RSEL_W-1:0]   ra_l, rb_l, rd_l;

  logic [W-1:0]        rf      [NUM_REGS];
  logic [W-1:0]        rf_view [NUM_REGS];
  logic [W-1:0]        ry;
  logic [2*W-1:0]      rz;
  logic [W-1:0]        bus;
  logic [2*W-1:0]      alu_rz;

  logic                accept;
  logic                op_bad;
  logic                pre_we;
  logic                wb_go;
  logic                wb_is_mul;
  logic                wb_rf_we;

  assign accept = (state == S_IDLE) && start;

  // Anything above NOT is undefined; the command still runs its full timing.
  assign op_bad    = (op_l > OP_NOT);
  assign wb_go     = (state == S_WB) && !op_bad;
  assign wb_is_mul = (op_l == OP_MUL);

  // R0 is hard-wired to zero when R0_ZERO is set, so writes to it are dropped.
  assign pre_we   = (state == S_IDLE) && ext_load_en &&
                    !((R0_ZERO != 0) && (ext_load_sel == '0));
  assign wb_rf_we = wb_go && !wb_is_mul &&
                    !((R0_ZERO != 0) && (rd_l == '0));

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_LOADY;
      S_LOADY: state_nx = S_EXEC;
      S_EXEC:  state_nx = S_WB;
      S_WB:    state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (clear) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      illegal_op <= 1'b0;
      op_l       <= OP_ADD;
      ra_l       <= '0;
      rb_l       <= '0;
      rd_l       <= '0;
    end else begin
      state      <= state_nx;
      // busy/done/illegal_op are registered: derive them from the state the
      // sequencer is about to enter (busy) or is leaving (done).
      busy       <= (state_nx != S_IDLE);
      done       <= (state == S_WB);
      illegal_op <= (state == S_WB) && op_bad;
      if (accept) begin
        op_l <= alu_op_e'(op);
        ra_l <= ra_sel;
        rb_l <= rb_sel;
        rd_l <= rd_sel;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file read view (R0 forced to zero when configured)
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      rf_view[i] = ((R0_ZERO != 0) && (i == 0)) ? '0 : rf[i];
    end
  end

  assign rd_port_data = rf_view[rd_port_sel];

  // Single shared bus: who drives it depends only on the micro-step.
  always_comb begin
    bus = '0;
    unique case (state)
      S_LOADY: bus = rf_view[ra_l];
      S_EXEC:  bus = rf_view[rb_l];
      S_WB:    bus = rz[W-1:0];
      default: bus = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU: A = RY, B = bus. Upper half is zero except for MUL.
  // ---------------------------------------------------------------------------
  logic [SH_W-1:0]     sh_amt;
  logic [2*W-1:0]      rot_r, rot_l;
  logic signed [2*W-1:0] prod;

  assign sh_amt = bus[SH_W-1:0];

  always_comb begin
    // Rotates via a doubled operand: amount 0 passes A through unchanged.
    rot_r  = {ry, ry} >> sh_amt;
    rot_l  = {ry, ry} << sh_amt;
    prod   = $signed({{W{ry[W-1]}}, ry}) * $signed({{W{bus[W-1]}}, bus});
    alu_rz = '0;
    case (op_l)
      OP_ADD:  alu_rz = {{W{1'b0}}, ry + bus};
      OP_SUB:  alu_rz = {{W{1'b0}}, ry - bus};
      OP_AND:  alu_rz = {{W{1'b0}}, ry & bus};
      OP_OR:   alu_rz = {{W{1'b0}}, ry | bus};
      OP_SHR:  alu_rz = {{W{1'b0}}, ry >> sh_amt};
      OP_SHL:  alu_rz = {{W{1'b0}}, ry << sh_amt};
      OP_ROR:  alu_rz = {{W{1'b0}}, rot_r[W-1:0]};
      OP_ROL:  alu_rz = {{W{1'b0}}, rot_l[2*W-1:W]};
      OP_MUL:  alu_rz = prod;
      OP_NEG:  alu_rz = {{W{1'b0}}, -bus};
      OP_NOT:  alu_rz = {{W{1'b0}}, ~bus};
      default: alu_rz = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: this register file is deliberately reset (all entries read 0 after
    // clear), which keeps it in flops rather than a RAM macro.
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else begin
      // Preload happens only in IDLE and writeback only in WB, so the two
      // ports can never collide.
      if (pre_we)   rf[ext_load_sel] <= ext_load_data;
      if (wb_rf_we) rf[rd_l]         <= bus;
    end
  end

  // ---------------------------------------------------------------------------
  // Staging and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (clear) begin
      ry         <= '0;
      rz         <= '0;
      hi_out     <= '0;
      lo_out     <= '0;
      result_out <= '0;
    end else begin
      if (state == S_LOADY) ry <= bus;
      if (state == S_EXEC)  rz <= alu_rz;
      if (wb_go) begin
        result_out <= bus;
        if (wb_is_mul) begin
          hi_out <= rz[2*W-1:W];
          lo_out <= bus;
        end
      end
    end
  end

endmodule
